multu_hilo_unit: RTL and testbench
==================================

// Module: multu_hilo_unit
// PURPOSE
//  Sequential 32x32 unsigned multiplier with HI/LO result registers; sits directly
//  downstream of the ALU control stage and consumes its 6-bit function code (SignaltoMULTU).
//  MULTU starts a 32-iteration shift-add multiply; MFHI/MFLO read HI/LO onto dataOut.
//  dataOut feeds the result MUX alongside the ALU and shifter outputs.
// PARAMETERS
//  WIDTH   32         operand width; HI/LO are each WIDTH bits, the product is 2*WIDTH
//  MULTU   6'b011001  function code that starts a multiply
//  MFHI    6'b010000  function code that reads HI
//  MFLO    6'b010010  function code that reads LO
// PORTS
//  clk      in   1      single clock; all state updates on posedge clk
//  reset    in   1      synchronous, active-high reset
//  Signal   in   6      function code from ALU control
//  start    in   1      one-cycle qualifier: accept Signal==MULTU this cycle
//  dataA    in   WIDTH  multiplicand (sampled at accept)
//  dataB    in   WIDTH  multiplier (sampled at accept)
//  busy     out  1      multiply in progress
//  done     out  1      one-cycle pulse when HI/LO have just been written
//  hi       out  WIDTH  HI register (upper product)
//  lo       out  WIDTH  LO register (lower product)
//  dataOut  out  WIDTH  registered MFHI/MFLO read data
// BEHAVIOUR
//  Reset (reset=1 at posedge): state=IDLE, busy=0, done=0, hi=0, lo=0, dataOut=0, counter=0.
//   Reset wins over every other event, including mid-multiply: the operation is aborted and no done pulse follows.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start && Signal==MULTU -> latch mcand=dataA, prod={WIDTH'b0,dataB}, counter=0, busy=1 -> RUN.
//         start with any other code: ignored.
//   RUN : per cycle, if prod[0] then prod[2W:W] = prod[2W-1:W] + mcand (W+1-bit sum, carry kept);
//         then prod >>= 1 (logical, carry enters MSB); counter++. After the 32nd step -> DONE.
//   DONE: hi<=prod[2W-1:W], lo<=prod[W-1:0], done=1 for exactly this cycle, busy=0 -> IDLE.
//  Latency: accept at edge 0; busy=1 from edge 0; done=1 and hi/lo valid after edge 33.
//   A new MULTU may be accepted in the cycle after DONE (issue interval 34 cycles).
//  start while busy (RUN or DONE): ignored; it does not restart and does not queue.
//  counter is 6 bits, compared against WIDTH; wrap is not reachable.
//  Operands are unsigned; the full 2W-bit product is exact, no overflow flag.
//  Reads: Signal==MFHI -> dataOut<=hi; Signal==MFLO -> dataOut<=lo (1-cycle latency, no start needed).
//   Any other code: dataOut holds its value.
//   Reads during RUN return the previous result.
//   A read sampled in the DONE cycle returns the pre-update value; the new value is visible from the next cycle.
//  hi/lo change only at DONE or on reset.
// STRUCTURE
//  Shared package alu_ops_pkg: function-code constants (AND/OR/ADD/SUB/SLT/SRL/MULTU/MFHI/MFLO),
//   shared with ALU control, ALU, shifter and MUX; FSM state encoding local (IDLE=0, RUN=1, DONE=2).
//  One sub-module: multu_step, a combinational single shift-add iteration
//   (in: prod[2W-1:0], mcand -> out: next prod).
//  Top level: FSM, counter, operand latch, HI/LO regs, read mux.
// TESTING
//  1. dataA=3, dataB=5, MULTU+start -> busy 33 cycles, done pulse after edge 33, hi=0, lo=15.
//  2. dataA=dataB=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (carry path).
//  3. dataA=32'h80000000, dataB=2 -> hi=1, lo=0; then MFHI -> dataOut=1, MFLO -> dataOut=0 one cycle later.
//  4. Start a second MULTU (7x9) at cycle 10 of a running 3x5 -> ignored; result hi=0, lo=15; single done pulse.
//  5. reset at cycle 12 of a multiply -> busy=0, hi=lo=dataOut=0, no done; a fresh 6x7 then gives lo=42.
//  6. Prior lo=15; new 6x7 running; MFLO during RUN and in the DONE cycle -> dataOut=15;
//     MFLO one cycle after DONE -> dataOut=42.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// Function codes shared by the ALU control, ALU, shifter, result mux and the multiplier.
package alu_ops_pkg;

    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_SLT = 6'b101010;
    localparam logic [5:0] ALU_SRL = 6'b000010;
    localparam logic [5:0] MULTU   = 6'b011001;
    localparam logic [5:0] MFHI    = 6'b010000;
    localparam logic [5:0] MFLO    = 6'b010010;

endpackage

// File: rtl/multu_step.sv
// One shift-add iteration of the unsigned multiplier: conditional add into the upper
// half with the carry kept, then a logical right shift that pulls the carry into the MSB.
module multu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] prod_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {sum, prod[WIDTH-1:1]};
    end

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned multiplier with HI/LO result registers and registered MFHI/MFLO
// read port; one multiply takes 34 cycles from accept to the next possible accept.
module multu_hilo_unit
    import alu_ops_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Signal,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         counter_q, counter_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               done_q, done_d;

    multu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prod     (prod_q),
        .mcand    (mcand_q),
        .prod_next(prod_step)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && Signal == MULTU) begin
                    mcand_d   = dataA;
                    prod_d    = {{WIDTH{1'b0}}, dataB};
                    counter_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                prod_d    = prod_step;
                counter_d = counter_q + 6'd1;
                if (counter_q == 6'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                hi_d    = prod_q[2*WIDTH-1:WIDTH];
                lo_d    = prod_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Reads see the registered hi/lo, so a read in the DONE cycle returns the old result.
    always_comb begin
        dout_d = dout_q;
        if (Signal == MFHI) begin
            dout_d = hi_q;
        end else if (Signal == MFLO) begin
            dout_d = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            counter_q <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign dataOut = dout_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: latency, carry path, reads, ignored restarts,
// mid-multiply reset and read timing around the DONE cycle.
module tb_multu_hilo_unit;

    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_NOP   = 6'b111111;

    logic        clk;
    logic        reset;
    logic [5:0]  Signal;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] dataOut;

    int checks = 0;
    int errors = 0;

    multu_hilo_unit #(
        .WIDTH(32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Signal (Signal),
        .start  (start),
        .dataA  (dataA),
        .dataB  (dataB),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .dataOut(dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting cycles that showed done and busy.
    task automatic run_cycles(input int n, output int dc, output int bc);
        dc = 0;
        bc = 0;
        repeat (n) begin
            tick();
            if (done) dc++;
            if (busy) bc++;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dataA  = a;
        dataB  = b;
        Signal = OP_MULTU;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        Signal = OP_NOP;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
        end
        checks++;
        if ({hi, lo, dataOut} !== 96'h0) begin
            errors++;
            $display("FAIL reset_regs: hi=%h lo=%h dataOut=%h required 0", hi, lo, dataOut);
        end
    endtask

    task automatic test_basic();
        int dc, bc;
        issue(32'd3, 32'd5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_at_accept: busy=%b required 1", busy);
        end
        run_cycles(32, dc, bc);
        checks++;
        if (dc !== 0 || bc !== 32) begin
            errors++;
            $display("FAIL basic_latency: done_cycles=%0d busy_cycles=%0d required 0/32", dc, bc);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b10 || hi !== 32'd0 || lo !== 32'd15) begin
            errors++;
            $display("FAIL basic_result: done=%b busy=%b hi=%h lo=%h required 1 0 0 f",
                     done, busy, hi, lo);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_carry();
        int dc, bc;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_cycles(33, dc, bc);
        checks++;
        if (dc !== 1 || bc !== 32 || done !== 1'b1) begin
            errors++;
            $display("FAIL carry_timing: done_cycles=%0d busy_cycles=%0d required 1/32", dc, bc);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL carry_result: hi=%h lo=%h required fffffffe 00000001", hi, lo);
        end
        tick();
    endtask

    task automatic test_read();
        int dc, bc;
        issue(32'h8000_0000, 32'd2);
        run_cycles(34, dc, bc);
        checks++;
        if (hi !== 32'd1 || lo !== 32'd0) begin
            errors++;
            $display("FAIL read_result: hi=%h lo=%h required 1 0", hi, lo);
        end
        Signal = OP_MFHI;
        tick();
        checks++;
        if (dataOut !== 32'd1) begin
            errors++;
            $display("FAIL read_mfhi: dataOut=%h required 1", dataOut);
        end
        Signal = OP_MFLO;
        tick();
        checks++;
        if (dataOut !== 32'd0) begin
            errors++;
            $display("FAIL read_mflo: dataOut=%h required 0", dataOut);
        end
        Signal = OP_MFHI;
        tick();
        Signal = OP_NOP;
        tick();
        tick();
        checks++;
        if (dataOut !== 32'd1) begin
            errors++;
            $display("FAIL read_hold: dataOut=%h required 1", dataOut);
        end
    endtask

    task automatic test_restart_ignored();
        int dc, bc, dc2, bc2;
        issue(32'd3, 32'd5);
        run_cycles(9, dc, bc);
        dataA  = 32'd7;
        dataB  = 32'd9;
        Signal = OP_MULTU;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        Signal = OP_NOP;
        run_cycles(23, dc, bc);
        checks++;
        if (dc !== 1 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) begin
            errors++;
            $display("FAIL restart_result: dones=%0d done=%b hi=%h lo=%h required 1 1 0 f",
                     dc, done, hi, lo);
        end
        run_cycles(40, dc2, bc2);
        checks++;
        if (dc2 !== 0 || bc2 !== 0) begin
            errors++;
            $display("FAIL restart_no_queue: dones=%0d busy_cycles=%0d required 0/0", dc2, bc2);
        end
    endtask

    task automatic test_reset_mid();
        int dc, bc;
        Signal = OP_MFLO;
        tick();
        Signal = OP_NOP;
        issue(32'd5, 32'd5);
        run_cycles(11, dc, bc);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {hi, lo, dataOut} !== 96'h0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b done=%b hi=%h lo=%h dataOut=%h required 0",
                     busy, done, hi, lo, dataOut);
        end
        run_cycles(40, dc, bc);
        checks++;
        if (dc !== 0 || bc !== 0) begin
            errors++;
            $display("FAIL midreset_aborted: dones=%0d busy_cycles=%0d required 0/0", dc, bc);
        end
        issue(32'd6, 32'd7);
        run_cycles(33, dc, bc);
        checks++;
        if (dc !== 1 || hi !== 32'd0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL midreset_fresh: dones=%0d hi=%h lo=%h required 1 0 2a", dc, hi, lo);
        end
        tick();
    endtask

    task automatic test_read_timing();
        int dc, bc;
        issue(32'd3, 32'd5);
        run_cycles(34, dc, bc);
        issue(32'd6, 32'd7);
        Signal = OP_MFLO;
        run_cycles(5, dc, bc);
        checks++;
        if (dataOut !== 32'd15) begin
            errors++;
            $display("FAIL rdtime_run: dataOut=%h required f", dataOut);
        end
        run_cycles(27, dc, bc);
        tick();
        checks++;
        if (dataOut !== 32'd15 || done !== 1'b1 || lo !== 32'd42) begin
            errors++;
            $display("FAIL rdtime_done_cycle: dataOut=%h done=%b lo=%h required f 1 2a",
                     dataOut, done, lo);
        end
        tick();
        checks++;
        if (dataOut !== 32'd42) begin
            errors++;
            $display("FAIL rdtime_after: dataOut=%h required 2a", dataOut);
        end
        Signal = OP_NOP;
    endtask

    task automatic test_back_to_back();
        int dc, bc;
        issue(32'd10, 32'd10);
        run_cycles(33, dc, bc);
        checks++;
        if (done !== 1'b1 || lo !== 32'd100) begin
            errors++;
            $display("FAIL b2b_first: done=%b lo=%h required 1 64", done, lo);
        end
        issue(32'd4, 32'd5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b required 1", busy);
        end
        run_cycles(33, dc, bc);
        checks++;
        if (dc !== 1 || hi !== 32'd0 || lo !== 32'd20) begin
            errors++;
            $display("FAIL b2b_second: dones=%0d hi=%h lo=%h required 1 0 14", dc, hi, lo);
        end
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        Signal = OP_NOP;
        start  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        test_reset();
        test_basic();
        test_carry();
        test_read();
        test_restart_ignored();
        test_reset_mid();
        test_read_timing();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
